// File: rtl/alu4_ctrl.sv
// Two-requester command front end for an 8-bit ALU operation.
// Each command runs as two 4-bit passes (low nibble, then high nibble) through one shared external ALU.
module alu4_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_zero,
    output logic       rsp_carry,
    output logic       rsp_overflow,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_c,
    output logic       alu_cin,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_overflow
);

    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

    state_t     state, state_nxt;
    logic       last_id;
    logic       grant_any, grant_id, accept;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a, cmd_b;
    logic       cmd_id;
    logic [3:0] lo_result_p0;
    logic       lo_carry_p0;
    logic [7:0] raw_p1, result_p1;

    function automatic logic is_arith(input logic [2:0] op);
        return op inside {3'b000, 3'b001, 3'b110, 3'b111};
    endfunction

    // Subtract-style ops run as an add of the inverted b with carry-in.
    function automatic logic is_sub(input logic [2:0] op);
        return op inside {3'b001, 3'b110, 3'b111};
    endfunction

    function automatic logic [2:0] alu_code(input logic [2:0] op);
        return is_sub(op) ? 3'b000 : op;
    endfunction

    function automatic logic [3:0] map_b(input logic [2:0] op, input logic [3:0] nib);
        return is_sub(op) ? ~nib : nib;
    endfunction

    // Ties go to the port that did not win last; ready is held off while rst is high.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant_id   = (req0_valid && req1_valid) ? ~last_id : req1_valid;
        accept     = (state == IDLE) && grant_any && !rst;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LO;
            LO:      state_nxt = HI;
            HI:      state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_a   = 4'd0;
        alu_b   = 4'd0;
        alu_c   = 3'd0;
        alu_cin = 1'b0;
        case (state)
            LO: begin
                alu_a   = cmd_a[3:0];
                alu_b   = map_b(cmd_op, cmd_b[3:0]);
                alu_c   = alu_code(cmd_op);
                alu_cin = is_sub(cmd_op);
            end
            HI: begin
                alu_a   = cmd_a[7:4];
                alu_b   = map_b(cmd_op, cmd_b[7:4]);
                alu_c   = alu_code(cmd_op);
                alu_cin = is_arith(cmd_op) & lo_carry_p0;
            end
            default: ;
        endcase
    end

    // Signed less-than is the sign of a-b corrected by overflow.
    always_comb begin
        raw_p1 = {alu_result, lo_result_p0};
        case (cmd_op)
            3'b110:  result_p1 = {7'b0, raw_p1[7] ^ alu_overflow};
            3'b111:  result_p1 = {7'b0, raw_p1 == 8'h00};
            default: result_p1 = raw_p1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_id      <= 1'b1;
            cmd_op       <= 3'd0;
            cmd_a        <= 8'd0;
            cmd_b        <= 8'd0;
            cmd_id       <= 1'b0;
            lo_result_p0 <= 4'd0;
            lo_carry_p0  <= 1'b0;
            rsp_result   <= 8'd0;
            rsp_zero     <= 1'b0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_id <= grant_id;
                cmd_id  <= grant_id;
                cmd_op  <= grant_id ? req1_op : req0_op;
                cmd_a   <= grant_id ? req1_a  : req0_a;
                cmd_b   <= grant_id ? req1_b  : req0_b;
            end
            // p0: low-nibble pass result captured
            if (state == LO) begin
                lo_result_p0 <= alu_result;
                lo_carry_p0  <= alu_carry;
            end
            // p1: high-nibble pass completes the response
            if (state == HI) begin
                rsp_result   <= result_p1;
                rsp_zero     <= (raw_p1 == 8'h00);
                rsp_carry    <= is_arith(cmd_op) & alu_carry;
                rsp_overflow <= is_arith(cmd_op) & alu_overflow;
            end
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_id    = cmd_id;

endmodule

// File: tb/tb_alu4_ctrl.sv
// Bench for alu4_ctrl: models the shared 4-bit ALU, applies a vector table,
// arbitration/backpressure/reset sequences and random commands against an 8-bit reference model.
module tb_alu4_ctrl;

    logic       clk, rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_result;
    logic       rsp_zero, rsp_carry, rsp_overflow;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_c;
    logic       alu_cin, alu_carry, alu_overflow;
    logic [4:0] tb_sum;

    int n_vec = 0;
    int n_err = 0;

    alu4_ctrl dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .rsp_overflow(rsp_overflow),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared external 4-bit ALU
    always_comb begin
        tb_sum       = 5'd0;
        alu_result   = 4'd0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_c)
            3'b000: begin
                tb_sum       = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
                alu_result   = tb_sum[3:0];
                alu_carry    = tb_sum[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (tb_sum[3] != alu_a[3]);
            end
            3'b010:  alu_result = ~alu_a;
            3'b011:  alu_result = alu_a & alu_b;
            3'b100:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = alu_a ^ alu_b;
            default: ;
        endcase
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        bit       port;
        bit [2:0] op;
        bit [7:0] a, b, res;
        bit       z, c, o;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-byte reference: arithmetic flags from 8-bit sums and comparisons.
    function automatic void ref_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                      output logic [7:0] res, output logic z, output logic c,
                                      output logic o);
        logic [8:0] s;
        logic [7:0] r;
        s = 9'd0;
        r = a - b;
        c = 1'b0;
        o = 1'b0;
        res = r;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                res = r;
                c = s[8];
                o = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'b010: begin r = ~a;    res = r; end
            3'b011: begin r = a & b; res = r; end
            3'b100: begin r = a | b; res = r; end
            3'b101: begin r = a ^ b; res = r; end
            default: begin
                c = (a >= b);
                o = (a[7] != b[7]) && (r[7] != a[7]);
                if (op == 3'b110) res = {7'b0, $signed(a) < $signed(b)};
                if (op == 3'b111) res = {7'b0, a == b};
            end
        endcase
        z = (r == 8'h00);
    endfunction

    task automatic drive_port(input bit port, input bit v, input logic [2:0] op,
                              input logic [7:0] a, input logic [7:0] b);
        if (port) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic accept_only(input bit port, input logic [2:0] op, input logic [7:0] a,
                               input logic [7:0] b, output bit ok);
        ok = 1'b0;
        drive_port(port, 1'b1, op, a, b);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (port ? req1_ready : req0_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 8'd0, 8'd1);
            drive_port(port, 1'b0, 3'd0, 8'd0, 8'd0);
            return;
        end
        @(posedge clk);
        #1;
        // Scramble the requester's fields; the in-flight command must not see them.
        drive_port(port, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // Returns at the negedge of the first DONE cycle.
    task automatic issue(input bit port, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, output bit ok);
        logic       sub;
        logic [3:0] bl;
        accept_only(port, op, a, b, ok);
        if (!ok) return;
        sub = (op == 3'b001) || (op == 3'b110) || (op == 3'b111);
        bl  = sub ? ~b[3:0] : b[3:0];
        @(negedge clk);
        chk("lo_rsp_valid", {7'b0, rsp_valid}, 8'd0);
        chk("lo_alu_a", {4'b0, alu_a}, {4'b0, a[3:0]});
        chk("lo_alu_b", {4'b0, alu_b}, {4'b0, bl});
        chk("lo_alu_c", {5'b0, alu_c}, sub ? 8'd0 : {5'b0, op});
        chk("lo_alu_cin", {7'b0, alu_cin}, {7'b0, sub});
        @(negedge clk);
        chk("hi_rsp_valid", {7'b0, rsp_valid}, 8'd0);
        chk("hi_alu_a", {4'b0, alu_a}, {4'b0, a[7:4]});
        @(negedge clk);
    endtask

    task automatic check_rsp(input string tag, input bit id, input logic [7:0] res,
                             input logic z, input logic c, input logic o);
        chk({tag, "_valid"}, {7'b0, rsp_valid}, 8'd1);
        chk({tag, "_id"}, {7'b0, rsp_id}, {7'b0, id});
        chk({tag, "_result"}, rsp_result, res);
        chk({tag, "_zero"}, {7'b0, rsp_zero}, {7'b0, z});
        chk({tag, "_carry"}, {7'b0, rsp_carry}, {7'b0, c});
        chk({tag, "_ovf"}, {7'b0, rsp_overflow}, {7'b0, o});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_port(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
        drive_port(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t       tbl[15];
    bit         ok;
    bit         ids[$];
    int         r0n, r1n;
    logic [7:0] e_res;
    logic       e_z, e_c, e_o;
    bit         rport;
    logic [2:0] rop;
    logic [7:0] ra, rb;

    initial begin
        //          port op      a      b      res    z  c  o
        tbl[0]  = '{1'b0, 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 3'b001, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 3'b001, 8'h01, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 3'b110, 8'hF0, 8'h05, 8'h01, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 3'b111, 8'h3C, 8'h3C, 8'h01, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 3'b011, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3'b100, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 3'b101, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 3'b010, 8'hFF, 8'h12, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 3'b001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 3'b110, 8'h05, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 3'b110, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 3'b000, 8'h08, 8'h08, 8'h10, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 3'b001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};

        rsp_ready = 1'b1;
        rst = 1'b1;
        drive_port(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
        drive_port(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("rst_rsp_valid", {7'b0, rsp_valid}, 8'd0);
        chk("rst_rsp_id", {7'b0, rsp_id}, 8'd0);
        chk("rst_rsp_result", rsp_result, 8'd0);
        chk("rst_flags", {5'b0, rsp_zero, rsp_carry, rsp_overflow}, 8'd0);
        chk("rst_alu", {alu_a, alu_c, alu_cin}, 8'd0);
        chk("rst_ready", {6'b0, req0_ready, req1_ready}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            issue(tbl[i].port, tbl[i].op, tbl[i].a, tbl[i].b, ok);
            if (ok) check_rsp("tbl", tbl[i].port, tbl[i].res, tbl[i].z, tbl[i].c, tbl[i].o);
        end

        // Both ports requesting from reset: strict alternation starting at port 0.
        do_reset();
        drive_port(1'b0, 1'b1, 3'b000, 8'h01, 8'h02);
        drive_port(1'b1, 1'b1, 3'b101, 8'h0F, 8'hFF);
        r0n = 0;
        r1n = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("rr_excl", {7'b0, req0_ready & req1_ready}, 8'd0);
            chk("rr_ready_idle", {7'b0, rsp_valid & (req0_ready | req1_ready)}, 8'd0);
            if (req0_ready) r0n++;
            if (req1_ready) r1n++;
            if (rsp_valid) begin
                ids.push_back(rsp_id);
                chk("rr_result", rsp_result, rsp_id ? 8'hF0 : 8'h03);
            end
            if (k == 11) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("rr_count", 8'(ids.size()), 8'd3);
        if (ids.size() >= 3) chk("rr_order", {5'b0, ids[0], ids[1], ids[2]}, 8'b010);
        chk("rr_ready0_pulses", 8'(r0n), 8'd2);
        chk("rr_ready1_pulses", 8'(r1n), 8'd1);

        // Backpressure: response held 5 cycles, no accept in DONE even once rsp_ready rises.
        rsp_ready = 1'b0;
        issue(1'b0, 3'b000, 8'h7F, 8'h01, ok);
        if (ok) begin
            drive_port(1'b0, 1'b1, 3'b011, 8'h11, 8'h22);
            drive_port(1'b1, 1'b1, 3'b100, 8'h33, 8'h44);
            for (int h = 0; h < 5; h++) begin
                #1;
                check_rsp("hold", 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
                chk("hold_ready", {6'b0, req0_ready, req1_ready}, 8'd0);
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            #1;
            chk("release_valid", {7'b0, rsp_valid}, 8'd1);
            chk("release_ready", {6'b0, req0_ready, req1_ready}, 8'd0);
            @(negedge clk);
            #1;
            chk("after_release_valid", {7'b0, rsp_valid}, 8'd0);
            chk("after_release_ready", {6'b0, req0_ready, req1_ready}, 8'b01);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            @(negedge clk);
        end

        // Reset during the high pass abandons the command.
        accept_only(1'b0, 3'b000, 8'h12, 8'h34, ok);
        if (ok) begin
            @(negedge clk);
            @(negedge clk);
            chk("pre_rst_hi_alu_a", {4'b0, alu_a}, 8'h01);
            rst = 1'b1;
            req0_valid = 1'b1;
            #1;
            chk("midrst_alu", {alu_a, alu_c, alu_cin}, 8'd0);
            chk("midrst_alu_b", {4'b0, alu_b}, 8'd0);
            for (int h = 0; h < 3; h++) begin
                @(negedge clk);
                chk("midrst_valid", {7'b0, rsp_valid}, 8'd0);
                chk("midrst_ready", {6'b0, req0_ready, req1_ready}, 8'd0);
            end
            rst = 1'b0;
            req0_valid = 1'b0;
            @(negedge clk);
            chk("post_rst_valid", {7'b0, rsp_valid}, 8'd0);
        end
        issue(1'b1, 3'b001, 8'h50, 8'h20, ok);
        if (ok) check_rsp("post_rst", 1'b1, 8'h30, 1'b0, 1'b1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rport = 1'($urandom);
            rop   = 3'($urandom);
            ra    = 8'($urandom);
            rb    = (n % 8 == 0) ? ra : 8'($urandom);
            ref_model(rop, ra, rb, e_res, e_z, e_c, e_o);
            issue(rport, rop, ra, rb, ok);
            if (ok) check_rsp("rand", rport, e_res, e_z, e_c, e_o);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
